// File: rtl/exec_mem_pkg.sv
// Shared types and constants for the execution-unit memory model.
package exec_mem_pkg;

  typedef enum logic [1:0] {
    FILL_RANDOM,
    FILL_ZERO,
    FILL_ADDR
  } fill_mode_e;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_DEPTH      = 16;
  localparam logic [31:0] DEF_SEED       = 32'hACE1_2468;
  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/exec_mem_if.sv
// Read/write port bundle between the execution unit and the memory model.
interface exec_mem_if #(
  parameter int unsigned ADDR_WIDTH = exec_mem_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = exec_mem_pkg::DEF_DATA_WIDTH
);
  logic                      exec_rd_req;
  logic [ADDR_WIDTH-1:0]     exec_rd_addr;
  logic                      exec_rd_ready;
  logic                      exec_rd_valid;
  logic [DATA_WIDTH-1:0]     exec_rd_data;
  logic                      exec_wr_req;
  logic [ADDR_WIDTH-1:0]     exec_wr_addr;
  logic [DATA_WIDTH-1:0]     exec_wr_data;
  logic [DATA_WIDTH/8-1:0]   exec_wr_be;
  logic [3:0]                rd_outstanding;

  modport master (
    output exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data, exec_wr_be,
    input  exec_rd_ready, exec_rd_valid, exec_rd_data, rd_outstanding
  );

  modport slave (
    input  exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data, exec_wr_be,
    output exec_rd_ready, exec_rd_valid, exec_rd_data, rd_outstanding
  );
endinterface

// File: rtl/exec_mem_lfsr.sv
// 32-bit Galois LFSR that can step 0..3 times per cycle.
module exec_mem_lfsr
  import exec_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seed,
  input  logic [1:0]  advance,
  output logic [31:0] value
);

  logic [31:0] r_state;
  logic [31:0] w_next;

  always_comb begin
    w_next = r_state;
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < advance) w_next = lfsr_step(w_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= seed;
    else        r_state <= w_next;
  end

  assign value = r_state;

endmodule

// File: rtl/exec_mem_model.sv
// Sparse read/write memory model with fixed read latency, fill policy and LFSR-driven stalls.
module exec_mem_model
  import exec_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned RD_LATENCY = 2,
  parameter fill_mode_e  FILL_MODE  = FILL_RANDOM,
  parameter int unsigned STALL_PCT  = 0,
  parameter logic [31:0] SEED       = DEF_SEED,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input logic       clk,
  input logic       rst_n,
  exec_mem_if.slave bus
);

  localparam int unsigned BE_W         = DATA_WIDTH / 8;
  localparam int unsigned IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          ALWAYS_STALL = (STALL_PCT >= 100);
  localparam bit          NEVER_STALL  = (STALL_PCT == 0);

  // Associative table: only touched addresses occupy an entry
  logic [DEPTH-1:0]      r_ent_v;
  logic [ADDR_WIDTH-1:0] r_ent_a [DEPTH];
  logic [DATA_WIDTH-1:0] r_ent_d [DEPTH];

  logic [RD_LATENCY-1:0] r_pipe_v;
  logic [DATA_WIDTH-1:0] r_pipe_d [RD_LATENCY];
  logic [3:0]            r_outst;

  logic [31:0]           w_lfsr, w_fill1, w_fill2;
  logic [1:0]            w_advance;
  logic                  w_stall, w_ready, w_accept;
  logic                  w_wr_do, w_wr_hit, w_rd_hit, w_wr_fill, w_rd_fill, w_same;
  logic [IDX_W-1:0]      w_wr_idx, w_rd_idx, w_free_a, w_free_b, w_rd_slot;
  logic                  w_free_a_ok, w_free_b_ok, w_wr_alloc, w_rd_alloc;
  logic [DATA_WIDTH-1:0] w_wr_old, w_wr_new, w_rd_val;

  function automatic logic [DATA_WIDTH-1:0] fill_val(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [31:0] rnd);
    case (FILL_MODE)
      FILL_ZERO: return '0;
      FILL_ADDR: return DATA_WIDTH'(a);
      default:   return DATA_WIDTH'(rnd);
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] be_merge(input logic [DATA_WIDTH-1:0] old,
                                                     input logic [DATA_WIDTH-1:0] wd,
                                                     input logic [BE_W-1:0] be);
    logic [DATA_WIDTH-1:0] r;
    r = old;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  exec_mem_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .seed    (SEED),
    .advance (w_advance),
    .value   (w_lfsr)
  );

  assign w_fill1 = lfsr_step(w_lfsr);
  assign w_fill2 = lfsr_step(w_fill1);
  assign w_stall = ALWAYS_STALL ? 1'b1 :
                   NEVER_STALL  ? 1'b0 : ((w_lfsr % 32'd100) < 32'(STALL_PCT));
  assign w_ready  = rst_n && !w_stall;
  assign w_accept = bus.exec_rd_req && w_ready;
  assign w_wr_do  = bus.exec_wr_req && (|bus.exec_wr_be);

  // Address lookup and the two lowest free slots
  always_comb begin
    w_wr_hit    = 1'b0;
    w_wr_idx    = '0;
    w_rd_hit    = 1'b0;
    w_rd_idx    = '0;
    w_free_a    = '0;
    w_free_b    = '0;
    w_free_a_ok = 1'b0;
    w_free_b_ok = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_ent_v[i] && r_ent_a[i] == bus.exec_wr_addr) begin
        w_wr_hit = 1'b1;
        w_wr_idx = IDX_W'(i);
      end
      if (r_ent_v[i] && r_ent_a[i] == bus.exec_rd_addr) begin
        w_rd_hit = 1'b1;
        w_rd_idx = IDX_W'(i);
      end
    end
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!r_ent_v[i]) begin
        w_free_b    = w_free_a;
        w_free_b_ok = w_free_a_ok;
        w_free_a    = IDX_W'(i);
        w_free_a_ok = 1'b1;
      end
    end
  end

  // Write fill takes the first extra LFSR step, read fill the next one
  always_comb begin
    w_wr_fill = w_wr_do && !w_wr_hit;
    w_wr_old  = w_wr_hit ? r_ent_d[w_wr_idx] : fill_val(bus.exec_wr_addr, w_fill1);
    w_wr_new  = be_merge(w_wr_old, bus.exec_wr_data, bus.exec_wr_be);
    w_same    = w_wr_do && (bus.exec_wr_addr == bus.exec_rd_addr);
    w_rd_fill = w_accept && !w_same && !w_rd_hit;
    if (w_same)        w_rd_val = w_wr_new;
    else if (w_rd_hit) w_rd_val = r_ent_d[w_rd_idx];
    else               w_rd_val = fill_val(bus.exec_rd_addr, w_wr_fill ? w_fill2 : w_fill1);
    w_rd_slot  = w_wr_fill ? w_free_b : w_free_a;
    w_wr_alloc = w_wr_fill && w_free_a_ok;
    w_rd_alloc = w_rd_fill && (w_wr_fill ? w_free_b_ok : w_free_a_ok);
    w_advance  = 2'd1;
    if (FILL_MODE == FILL_RANDOM) w_advance = 2'd1 + 2'(w_wr_fill) + 2'(w_rd_fill);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent_v <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_ent_a[i] <= '0;
        r_ent_d[i] <= '0;
      end
    end else begin
      if (w_wr_do && w_wr_hit) r_ent_d[w_wr_idx] <= w_wr_new;
      if (w_wr_alloc) begin
        r_ent_v[w_free_a] <= 1'b1;
        r_ent_a[w_free_a] <= bus.exec_wr_addr;
        r_ent_d[w_free_a] <= w_wr_new;
      end
      if (w_rd_alloc) begin
        r_ent_v[w_rd_slot] <= 1'b1;
        r_ent_a[w_rd_slot] <= bus.exec_rd_addr;
        r_ent_d[w_rd_slot] <= w_rd_val;
      end
    end
  end

  // Read return pipeline; data registers hold when no valid item shifts in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_v <= '0;
      r_outst  <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) r_pipe_d[i] <= '0;
    end else begin
      r_pipe_v[0] <= w_accept;
      if (w_accept) r_pipe_d[0] <= w_rd_val;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        r_pipe_v[i] <= r_pipe_v[i-1];
        if (r_pipe_v[i-1]) r_pipe_d[i] <= r_pipe_d[i-1];
      end
      r_outst <= r_outst + 4'(w_accept) - 4'(r_pipe_v[RD_LATENCY-1]);
    end
  end

  assign bus.exec_rd_ready  = w_ready;
  assign bus.exec_rd_valid  = r_pipe_v[RD_LATENCY-1];
  assign bus.exec_rd_data   = r_pipe_d[RD_LATENCY-1];
  assign bus.rd_outstanding = r_outst;

endmodule

// File: tb/tb_exec_mem_model.sv
// Directed and randomized checks of exec_mem_model against a behavioural reference.
module tb_exec_mem_model;
  import exec_mem_pkg::*;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 32;
  localparam int          NCYC = 300;

  typedef struct {
    int          due;
    logic [31:0] data;
  } ret_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  exec_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bz ();
  exec_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ba ();
  exec_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) br ();
  exec_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bs ();

  exec_mem_model #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3), .FILL_MODE(FILL_ZERO),
                   .STALL_PCT(0), .SEED(DEF_SEED), .DEPTH(16))
    u_z (.clk(clk), .rst_n(rst_n), .bus(bz));
  exec_mem_model #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .FILL_MODE(FILL_ADDR),
                   .STALL_PCT(0), .SEED(DEF_SEED), .DEPTH(16))
    u_a (.clk(clk), .rst_n(rst_n), .bus(ba));
  exec_mem_model #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .FILL_MODE(FILL_RANDOM),
                   .STALL_PCT(30), .SEED(DEF_SEED), .DEPTH(16))
    u_r (.clk(clk), .rst_n(rst_n), .bus(br));
  exec_mem_model #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .FILL_MODE(FILL_RANDOM),
                   .STALL_PCT(100), .SEED(DEF_SEED), .DEPTH(16))
    u_s (.clk(clk), .rst_n(rst_n), .bus(bs));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] s);
    if (s[0]) return (s >> 1) ^ LFSR_POLY;
    return s >> 1;
  endfunction

  function automatic logic [31:0] be_apply(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic idle_all();
    bz.exec_rd_req = 0; bz.exec_rd_addr = '0; bz.exec_wr_req = 0;
    bz.exec_wr_addr = '0; bz.exec_wr_data = '0; bz.exec_wr_be = '0;
    ba.exec_rd_req = 0; ba.exec_rd_addr = '0; ba.exec_wr_req = 0;
    ba.exec_wr_addr = '0; ba.exec_wr_data = '0; ba.exec_wr_be = '0;
    br.exec_rd_req = 0; br.exec_rd_addr = '0; br.exec_wr_req = 0;
    br.exec_wr_addr = '0; br.exec_wr_data = '0; br.exec_wr_be = '0;
    bs.exec_rd_req = 0; bs.exec_rd_addr = '0; bs.exec_wr_req = 0;
    bs.exec_wr_addr = '0; bs.exec_wr_data = '0; bs.exec_wr_be = '0;
  endtask

  // Read on u_z (latency 3), optionally with a same-edge write, and check the return
  task automatic z_read(input logic [15:0] a, input bit wr, input logic [31:0] wd,
                        input logic [31:0] exp, input string tag);
    @(negedge clk);
    bz.exec_rd_req = 1; bz.exec_rd_addr = a;
    if (wr) begin
      bz.exec_wr_req = 1; bz.exec_wr_addr = a; bz.exec_wr_data = wd; bz.exec_wr_be = 4'hF;
    end
    @(negedge clk);
    bz.exec_rd_req = 0; bz.exec_wr_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(bz.exec_rd_valid), 64'(1));
    chk({tag, "_data"}, 64'(bz.exec_rd_data), 64'(exp));
  endtask

  logic        rq [NCYC];
  logic [15:0] ra [NCYC];
  logic        wq [NCYC];
  logic [15:0] wa [NCYC];
  logic [31:0] wd [NCYC];
  logic [3:0]  wb [NCYC];
  logic [31:0] tr_d [NCYC];
  logic        tr_r [NCYC];
  logic [31:0] mem [logic [15:0]];
  ret_t        q [$];

  initial begin
    logic [31:0] m_lfsr, t, last;
    logic        rdy_e, v_e;
    int          stall_hits, peak;
    int          exp_o [7];
    ret_t        r;
    exp_o = '{0, 1, 2, 2, 2, 1, 0};
    stall_hits = 0;
    peak = 0;

    idle_all();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bz.exec_rd_valid), 64'(0));
    chk("rst_data", 64'(bz.exec_rd_data), 64'(0));
    chk("rst_ready", 64'(bz.exec_rd_ready), 64'(0));
    chk("rst_outst", 64'(bz.rd_outstanding), 64'(0));
    chk("rst_ready_r", 64'(br.exec_rd_ready), 64'(0));

    // First accept right after reset release; valid exactly 3 cycles later
    @(negedge clk);
    rst_n = 1;
    bz.exec_rd_req = 1; bz.exec_rd_addr = 16'h0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("lat3_outst", 64'(bz.rd_outstanding), 64'(1));
        bz.exec_rd_req = 0;
      end
      chk("lat3_valid", 64'(bz.exec_rd_valid), 64'(k == 2));
      if (k == 2) chk("lat3_data", 64'(bz.exec_rd_data), 64'(0));
    end

    @(negedge clk);
    bz.exec_wr_req = 1; bz.exec_wr_addr = 16'h0020;
    bz.exec_wr_data = 32'hDEADBEEF; bz.exec_wr_be = 4'b0101;
    @(negedge clk);
    bz.exec_wr_req = 0;
    z_read(16'h0020, 1'b0, '0, 32'h00AD00EF, "partial_be");
    z_read(16'h0030, 1'b1, 32'h12345678, 32'h12345678, "write_first");

    // Write landing behind an in-flight read must not change that read
    @(negedge clk);
    bz.exec_rd_req = 1; bz.exec_rd_addr = 16'h0030;
    @(negedge clk);
    bz.exec_rd_req = 0;
    bz.exec_wr_req = 1; bz.exec_wr_addr = 16'h0030; bz.exec_wr_data = 32'hCAFEF00D;
    bz.exec_wr_be = 4'hF;
    @(negedge clk);
    bz.exec_wr_req = 0;
    @(negedge clk);
    chk("inflight_data", 64'(bz.exec_rd_data), 64'h12345678);
    z_read(16'h0030, 1'b0, '0, 32'hCAFEF00D, "after_write");

    // Reset with two reads in flight and a request held through reset
    @(negedge clk);
    bz.exec_rd_req = 1; bz.exec_rd_addr = 16'h0020;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_outst", 64'(bz.rd_outstanding), 64'(2));
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 64'(bz.exec_rd_valid), 64'(0));
    chk("mid_rst_data", 64'(bz.exec_rd_data), 64'(0));
    chk("mid_rst_ready", 64'(bz.exec_rd_ready), 64'(0));
    chk("mid_rst_outst", 64'(bz.rd_outstanding), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    bz.exec_rd_req = 0;
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_valid", 64'(bz.exec_rd_valid), 64'(0));
      chk("post_rst_outst", 64'(bz.rd_outstanding), 64'(0));
    end
    z_read(16'h0020, 1'b0, '0, 32'h0, "post_rst_fill");

    // Four back-to-back reads, FILL_ADDR, latency 2
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("b2b_valid", 64'(ba.exec_rd_valid), 64'(k >= 2 && k <= 5));
      chk("b2b_outst", 64'(ba.rd_outstanding), 64'(exp_o[k]));
      if (int'(ba.rd_outstanding) > peak) peak = int'(ba.rd_outstanding);
      if (k >= 2) chk("b2b_data", 64'(ba.exec_rd_data), 64'((k <= 5) ? k - 1 : 4));
      ba.exec_rd_req = (k < 4);
      ba.exec_rd_addr = 16'(k + 1);
    end
    chk("b2b_peak", 64'(peak), 64'(2));

    for (int c = 0; c < NCYC; c++) begin
      rq[c] = ($urandom_range(0, 9) < 7);
      ra[c] = 16'h0040 + 16'($urandom_range(0, 7));
      wq[c] = ($urandom_range(0, 1) == 1);
      wa[c] = 16'h0040 + 16'($urandom_range(0, 7));
      wd[c] = $urandom;
      wb[c] = 4'($urandom_range(0, 15));
    end

    // Same stimulus twice from reset; second pass must reproduce the first
    for (int run = 0; run < 2; run++) begin
      rst_n = 0;
      idle_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      #1;
      mem.delete();
      q.delete();
      m_lfsr = DEF_SEED;
      last = '0;
      for (int c = 0; c < NCYC; c++) begin
        if (c > 0) @(negedge clk);
        rdy_e = !((m_lfsr % 32'd100) < 32'd30);
        v_e = (q.size() > 0) && (q[0].due == c);
        chk("rnd_ready", 64'(br.exec_rd_ready), 64'(rdy_e));
        chk("rnd_outst", 64'(br.rd_outstanding), 64'(q.size()));
        chk("rnd_valid", 64'(br.exec_rd_valid), 64'(v_e));
        if (v_e) begin
          last = q[0].data;
          void'(q.pop_front());
        end
        chk("rnd_data", 64'(br.exec_rd_data), 64'(last));
        if (bs.exec_rd_ready) stall_hits++;
        if (run == 0) begin
          tr_d[c] = br.exec_rd_data;
          tr_r[c] = br.exec_rd_ready;
        end else begin
          chk("rerun_data", 64'(br.exec_rd_data), 64'(tr_d[c]));
          chk("rerun_ready", 64'(br.exec_rd_ready), 64'(tr_r[c]));
        end

        br.exec_rd_req = rq[c]; br.exec_rd_addr = ra[c];
        br.exec_wr_req = wq[c]; br.exec_wr_addr = wa[c];
        br.exec_wr_data = wd[c]; br.exec_wr_be = wb[c];
        bs.exec_rd_req = rq[c]; bs.exec_rd_addr = ra[c];

        t = m_lfsr;
        if (wq[c] && wb[c] != 4'd0) begin
          if (!mem.exists(wa[c])) begin
            t = m_step(t);
            mem[wa[c]] = t;
          end
          mem[wa[c]] = be_apply(mem[wa[c]], wd[c], wb[c]);
        end
        if (rq[c] && rdy_e) begin
          if (!mem.exists(ra[c])) begin
            t = m_step(t);
            mem[ra[c]] = t;
          end
          r.due = c + 2;
          r.data = mem[ra[c]];
          q.push_back(r);
        end
        m_lfsr = m_step(t);
      end
    end
    chk("stall100_ready_hits", 64'(stall_hits), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
